// File: rtl/fifo_burst_reader.sv
// Pops length-counted bursts from a FWFT sync_fifo into a valid/ready stream with last on the final word.
// Latency: pop-to-valid 1 cycle. Backpressure: a 2-entry skid buffer absorbs stalls; pops stop when it is full.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [LEN_WIDTH-1:0]  cmd_len_in,
  output logic                  fifo_pop_req_out,
  input  logic                  fifo_empty_in,
  input  logic                  fifo_almost_empty_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  m_valid_out,
  input  logic                  m_ready_in,
  output logic [DATA_WIDTH-1:0] m_data_out,
  output logic                  m_last_out,
  output logic                  busy_out,
  output logic [LEN_WIDTH:0]    words_left_out
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH:0]    pop_cnt_q, pop_cnt_d;
  logic [LEN_WIDTH:0]    words_left_q, words_left_d;
  logic                  popped_q;
  logic [DATA_WIDTH-1:0] buf_dat_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            buf_cnt_q;

  logic pop, last_wr, accept, head_last;

  // The empty flag lags occupancy by a cycle, so back-to-back pops need almost_empty low.
  assign pop = (state_q == BURST) && (pop_cnt_q != '0) && (buf_cnt_q != 2'd2) &&
               !fifo_empty_in && (!popped_q || !fifo_almost_empty_in);
  assign last_wr   = (pop_cnt_q == (LEN_WIDTH+1)'(1));
  assign head_last = buf_last_q[rd_ptr_q];
  assign accept    = m_valid_out && m_ready_in;

  assign fifo_pop_req_out = pop;
  assign m_valid_out      = (buf_cnt_q != 2'd0);
  assign m_data_out       = buf_dat_q[rd_ptr_q];
  assign m_last_out       = m_valid_out && head_last;
  assign busy_out         = (state_q != IDLE);
  assign words_left_out   = words_left_q;

  always_comb begin
    state_d       = state_q;
    pop_cnt_d     = pop_cnt_q - (LEN_WIDTH+1)'(pop);
    words_left_d  = words_left_q - (LEN_WIDTH+1)'(accept);
    cmd_ready_out = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) begin
          pop_cnt_d    = {1'b0, cmd_len_in} + (LEN_WIDTH+1)'(1);
          words_left_d = {1'b0, cmd_len_in} + (LEN_WIDTH+1)'(1);
          state_d      = BURST;
        end
      end
      BURST: if (pop && last_wr) state_d = DRAIN;
      DRAIN: if (accept && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pop_cnt_q    <= '0;
      words_left_q <= '0;
      popped_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_cnt_q    <= pop_cnt_d;
      words_left_q <= words_left_d;
      popped_q     <= pop;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        buf_dat_q[i]  <= '0;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      buf_cnt_q <= 2'd0;
    end else begin
      if (pop) begin
        buf_dat_q[wr_ptr_q]  <= fifo_data_in;
        buf_last_q[wr_ptr_q] <= last_wr;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (accept) rd_ptr_q <= ~rd_ptr_q;
      buf_cnt_q <= buf_cnt_q + 2'(pop) - 2'(accept);
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader driving a behavioural sync_fifo whose flags lag occupancy by one cycle.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [LW-1:0] cmd_len_in;
  logic          fifo_pop_req_out;
  logic          fifo_empty_in;
  logic          fifo_almost_empty_in;
  logic [DW-1:0] fifo_data_in;
  logic          m_valid_out;
  logic          m_ready_in;
  logic [DW-1:0] m_data_out;
  logic          m_last_out;
  logic          busy_out;
  logic [LW:0]   words_left_out;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_len_in(cmd_len_in),
    .fifo_pop_req_out(fifo_pop_req_out), .fifo_empty_in(fifo_empty_in),
    .fifo_almost_empty_in(fifo_almost_empty_in), .fifo_data_in(fifo_data_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out),
    .m_last_out(m_last_out), .busy_out(busy_out), .words_left_out(words_left_out)
  );

  // Behavioural FIFO: flags are registered from the current count, so they trail it by one cycle.
  logic [DW-1:0] fmem [0:255];
  int unsigned   frd = 0, fwr = 0;
  logic          empty_r = 1'b1, ae_r = 1'b1;
  logic          ae_force;
  logic          push_en;
  logic [DW-1:0] push_dat;
  int            cyc = 0, last_pop_cyc = -10;
  int            pop_empty_err = 0, gap_err = 0, pop_total = 0, acc_total = 0;

  assign fifo_empty_in        = empty_r;
  assign fifo_almost_empty_in = ae_r | ae_force;
  assign fifo_data_in         = fmem[frd[7:0]];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    empty_r <= (fwr == frd);
    ae_r    <= ((fwr - frd) <= 1);
    if (push_en) begin
      fmem[fwr[7:0]] <= push_dat;
      fwr            <= fwr + 1;
    end
    if (fifo_pop_req_out) begin
      if (fwr == frd) pop_empty_err <= pop_empty_err + 1;
      else frd <= frd + 1;
      if (fifo_almost_empty_in && (last_pop_cyc == cyc - 1)) gap_err <= gap_err + 1;
      pop_total    <= pop_total + 1;
      last_pop_cyc <= cyc;
    end
    if (m_valid_out && m_ready_in) acc_total <= acc_total + 1;
  end

  // Stream monitor: record accepted beats, check hold-stable under stall, track buffer occupancy.
  logic [DW:0]   out_q [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  int            stall_err = 0, max_occ = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid_out && m_ready_in) out_q.push_back({m_last_out, m_data_out});
      if (prev_stall && (!m_valid_out || m_data_out != prev_dat)) stall_err <= stall_err + 1;
      prev_stall <= m_valid_out && !m_ready_in;
      prev_dat   <= m_data_out;
      if (pop_total - acc_total > max_occ) max_occ <= pop_total - acc_total;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int            n_chk = 0, n_fail = 0;
  int            oi = 0, ph = 0;
  logic [3:0]    rdy_pat;
  logic [DW-1:0] pend [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_ready_in = rdy_pat[ph];
    ph = (ph + 1) % 4;
    if (pend.size() > 0) begin
      push_en  = 1'b1;
      push_dat = pend.pop_front();
    end else begin
      push_en = 1'b0;
    end
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) pend.push_back(base + DW'(i));
    repeat (n + 4) step();
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    cmd_valid_in = 1'b1;
    cmd_len_in   = len;
    for (int i = 0; i < 50 && !cmd_ready_out; i++) step();
    step();
    cmd_valid_in = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_rdy"}, 32'(cmd_ready_out), 1);
    chk({tag, "_pop"}, 32'(fifo_pop_req_out), 0);
    chk({tag, "_valid"}, 32'(m_valid_out), 0);
    chk({tag, "_last"}, 32'(m_last_out), 0);
    chk({tag, "_data"}, 32'(m_data_out), 0);
    chk({tag, "_busy"}, 32'(busy_out), 0);
    chk({tag, "_wleft"}, 32'(words_left_out), 0);
  endtask

  // Step until the last beat is accepted, then check the block is back in IDLE.
  task automatic wait_last(input string tag);
    logic hs;
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      hs = m_valid_out && m_ready_in && m_last_out;
      step();
      if (hs) done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy_out), 0);
    chk({tag, "_cmd_rdy_end"}, 32'(cmd_ready_out), 1);
    chk({tag, "_wleft_end"}, 32'(words_left_out), 0);
  endtask

  task automatic check_beats(input string tag, input logic [DW-1:0] base, input int n);
    logic [DW:0] e;
    chk({tag, "_count"}, 32'(out_q.size() - oi), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1), base + DW'(i)};
      chk({tag, "_beat"}, (oi + i < out_q.size()) ? 32'(out_q[oi + i]) : 32'hDEAD_0000, 32'(e));
    end
    oi = out_q.size();
  endtask

  initial begin
    rstn         = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_len_in   = '0;
    ae_force     = 1'b0;
    push_en      = 1'b0;
    push_dat     = '0;
    rdy_pat      = 4'hF;
    m_ready_in   = 1'b1;
    #1;
    chk_reset("rst");

    // Test 1: 16-word burst at full rate.
    push_words(16'h0001, 16);
    rstn = 1'b1;
    repeat (3) step();
    send_cmd(8'd15);
    chk("t1_wleft_start", 32'(words_left_out), 16);
    chk("t1_busy", 32'(busy_out), 1);
    chk("t1_cmd_rdy_low", 32'(cmd_ready_out), 0);
    chk("t1_first_pop", 32'(fifo_pop_req_out), 1);
    chk("t1_no_valid_yet", 32'(m_valid_out), 0);
    step();
    chk("t1_valid_next", 32'(m_valid_out), 1);
    chk("t1_first_data", 32'(m_data_out), 16'h0001);
    wait_last("t1");
    check_beats("t1", 16'h0001, 16);

    // Test 2: FIFO runs dry mid-burst, refilled later.
    push_words(16'h0021, 3);
    send_cmd(8'd7);
    repeat (10) step();
    chk("t2_stalled_busy", 32'(busy_out), 1);
    for (int i = 0; i < 5; i++) pend.push_back(16'h0024 + 16'(i));
    wait_last("t2");
    check_beats("t2", 16'h0021, 8);
    chk("t2_pop_empty", 32'(pop_empty_err), 0);

    // Test 3: downstream ready 1,0,0,1 repeating.
    push_words(16'h0031, 6);
    rdy_pat = 4'b1001;
    send_cmd(8'd5);
    wait_last("t3");
    check_beats("t3", 16'h0031, 6);
    chk("t3_stall_stable", 32'(stall_err), 0);
    chk("t3_occ_le2", 32'(max_occ <= 2), 1);
    rdy_pat = 4'hF;

    // Test 4: single-word burst.
    push_words(16'hABCD, 1);
    send_cmd(8'd0);
    wait_last("t4");
    check_beats("t4", 16'hABCD, 1);

    // Test 5: reset after 4 of 10 words; word 5 sits in the buffer and is discarded.
    push_words(16'h0051, 12);
    send_cmd(8'd9);
    for (int i = 0; i < 100 && (out_q.size() - oi) < 4; i++) step();
    chk("t5_mid_wleft", 32'(words_left_out), 6);
    rstn = 1'b0;
    #1;
    chk_reset("t5_rst");
    oi = out_q.size();
    repeat (2) step();
    rstn = 1'b1;
    step();
    send_cmd(8'd1);
    wait_last("t5");
    check_beats("t5", 16'h0056, 2);

    // Test 6: almost_empty held high, pops must be spaced.
    ae_force = 1'b1;
    send_cmd(8'd3);
    wait_last("t6");
    check_beats("t6", 16'h0058, 4);
    chk("t6_pop_gap", 32'(gap_err), 0);
    chk("t6_pop_empty", 32'(pop_empty_err), 0);
    ae_force = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drains the pop side of a `sync_fifo` instance.
- Converts it into a valid/ready stream in length-counted bursts: one command of N words makes the block pop exactly N words from the FIFO and present them downstream, with `m_last_out` on the final word.
- Sits between a `sync_fifo` (first-word fall-through: FIFO data is valid combinationally at its current read pointer) and a downstream consumer such as a DMA write engine.

Parameters:
- DATA_WIDTH, 16, width of FIFO and stream data words.
- LEN_WIDTH, 8, width of burst length field; burst = `cmd_len_in`+1 words (1..2^LEN_WIDTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- cmd_valid_in  input  1  burst command valid.
- cmd_ready_out  output  1  command accepted when both valid and ready are high.
- cmd_len_in  input  LEN_WIDTH  burst length minus one.
- fifo_pop_req_out  output  1  pop request to FIFO; data sampled the same cycle.
- fifo_empty_in  input  1  FIFO empty flag (registered in the FIFO; reflects occupancy one cycle late).
- fifo_almost_empty_in  input  1  FIFO almost-empty flag (AE_LEVEL ≥ 1).
- fifo_data_in  input  DATA_WIDTH  FIFO head word.
- m_valid_out  output  1  stream word valid.
- m_ready_in  input  1  downstream ready.
- m_data_out  output  DATA_WIDTH  stream word.
- m_last_out  output  1  final word of burst, qualified by `m_valid_out`.
- busy_out  output  1  state != IDLE.
- words_left_out  output  LEN_WIDTH+1  words not yet accepted downstream in current burst.

Behaviour:

Reset (async assert, sync release):
- state=IDLE; `cmd_ready_out`=1; `fifo_pop_req_out`=0; `m_valid_out`=0; `m_last_out`=0; `m_data_out`=0; `busy_out`=0; `words_left_out`=0.
- Output buffer is emptied.
- Reset mid-burst discards all in-flight words and any remaining count.

State machine:
- IDLE: `cmd_ready_out`=1. On `cmd_valid_in` high, latch pop_cnt=`cmd_len_in`+1 and words_left=`cmd_len_in`+1, then go to BURST.
- BURST: pop while pop_cnt>0. When the pop that brings pop_cnt to 0 is issued, go to DRAIN.
- DRAIN: no pops. When the word with last=1 is accepted downstream, go to IDLE.
- `cmd_ready_out`=0 outside IDLE. Back-to-back bursts have a minimum 1-cycle IDLE gap.

Pop rule (all must hold in BURST, combinational from registers and FIFO flags only; no path from `m_ready_in`):
- pop_cnt>0.
- buf_cnt<2.
- `fifo_empty_in`=0.
- Either no pop was issued in the previous cycle, or `fifo_almost_empty_in`=0. This rule compensates for the one-cycle-late empty flag, so the FIFO is never popped while empty.

Output buffer:
- 2-entry skid FIFO holding {data, last}. On a pop cycle, `fifo_data_in` is written in the same cycle.
- last=1 on the pop that brings pop_cnt 1→0.
- A word written this cycle is visible on `m_data_out` at the next cycle at the earliest (pop-to-valid latency 1).
- `m_valid_out`=(buf_cnt>0). `m_data_out`/`m_last_out` show the buffer head and are held stable while valid && !ready.
- Simultaneous write and read: buf_cnt unchanged, order preserved.

Counters:
- words_left decrements on each accepted stream word (`m_valid_out` && `m_ready_in`).
- Saturation is impossible by construction. The maximum value 2^LEN_WIDTH requires the extra bit.

Throughput:
- 1 word/cycle sustained while `fifo_almost_empty_in`=0 and downstream is always ready.
- 1 word per 2 cycles while `fifo_almost_empty_in`=1 and `fifo_empty_in`=0.

Boundaries:
- FIFO empty mid-burst: block stalls in BURST with no timeout.
- Downstream stall: at most 2 words are popped beyond the last acceptance.
- `cmd_len_in`=0 gives a 1-word burst with last=1 on that word.
- `cmd_len_in`=all ones gives 2^LEN_WIDTH words.

Test Plan:
1. FIFO preloaded with 0x0001..0x0010, `m_ready_in`=1, cmd len=15 → 16 words in order, `m_last_out` only on 0x0010, `busy_out` falls the cycle after the last handshake, `words_left_out` 16→0.
2. FIFO holds 3 words, cmd len=7, 5 more words pushed 10 cycles later → `fifo_pop_req_out` never high while the FIFO is empty; 8 words out in order, last on word 8.
3. Burst len=5 with `m_ready_in` toggling 1,0,0,1 repeating → no word lost or duplicated; data held stable during stalls; at most 2 words in the buffer.
4. `cmd_len_in`=0 with FIFO word 0xABCD → one beat 0xABCD with last=1; `cmd_ready_out` returns to 1 the next cycle.
5. `rstn` pulled low mid-burst (4 of 10 words delivered) → all outputs reach reset values immediately; a new cmd len=1 after release delivers the next 2 FIFO words with correct last.
6. `fifo_almost_empty_in`=1 throughout, len=3 → pops spaced at least 2 cycles apart; 4 words delivered correctly.
